// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
//   Cleans up raw switches and bouncing push-buttons in front of the ALU top.
//   Every raw input passes through a 2-flop synchronizer. Each button then
//   produces a single one-cycle press pulse. When several buttons fire on
//   the same edge, only the highest-index pulse is issued. The synchronized
//   switch value is captured on the edge that issues a pulse.
//
//   Build option:
//     INPUT_CONDITIONER_DEBOUNCE_EN defined   : per-button debounce FSM
//                                               (LOW/WAIT_HIGH/HIGH/WAIT_LOW).
//                                               The pulse comes DB_CYCLES+3
//                                               edges after the first high
//                                               sample.
//     INPUT_CONDITIONER_DEBOUNCE_EN undefined : the pulse is a rising-edge
//                                               detect of the synchronized
//                                               level. It comes 3 edges after
//                                               the first high sample.
//
//   Parameters:
//     N_SW      : switch bus width
//     N_B       : button count (bit 2 = load A, bit 1 = load B, bit 0 = load OP)
//     DB_CYCLES : consecutive equal samples that qualify a level change (>= 2)
//
//   Ports:
//     clock     : single clock
//     reset     : asynchronous, active-low reset
//     i_SWs     : raw asynchronous switch levels
//     i_buttons : raw asynchronous bouncing buttons, active-high
//     o_SWs     : switch value captured with the last press pulse
//     o_buttons : registered one-cycle press pulses, at most one hot
// ---------------------------------------------------------------------------
module input_conditioner #(
  parameter int unsigned N_SW      = 6,
  parameter int unsigned N_B       = 3,
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_SW-1:0] i_SWs,
  input  logic [N_B-1:0]  i_buttons,
  output logic [N_SW-1:0] o_SWs,
  output logic [N_B-1:0]  o_buttons
);

  // A window shorter than two samples cannot reject a single-cycle glitch.
  if (DB_CYCLES < 2) begin : g_db_cycles_invalid
    $error("input_conditioner: DB_CYCLES must be at least 2");
  end

  logic [N_B-1:0]  btn_meta;
  logic [N_B-1:0]  btn_sync;
  logic [N_SW-1:0] sw_meta;
  logic [N_SW-1:0] sw_sync;
  logic [N_B-1:0]  press_req;
  logic [N_B-1:0]  grant_c;

  // Two-flop synchronizers for every raw input bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_meta <= '0;
      btn_sync <= '0;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      btn_meta <= i_buttons;
      btn_sync <= btn_meta;
      sw_meta  <= i_SWs;
      sw_sync  <= sw_meta;
    end
  end

`ifdef INPUT_CONDITIONER_DEBOUNCE_EN

  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

  localparam logic [1:0] ST_LOW       = 2'd0;
  localparam logic [1:0] ST_WAIT_HIGH = 2'd1;
  localparam logic [1:0] ST_HIGH      = 2'd2;
  localparam logic [1:0] ST_WAIT_LOW  = 2'd3;

  // Count value whose next agreeing sample completes the window.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_q [N_B];
  logic [1:0]       state_d [N_B];
  logic [CNT_W-1:0] cnt_q   [N_B];
  logic [CNT_W-1:0] cnt_d   [N_B];
  logic [N_B-1:0]   req_d;
  logic [N_B-1:0]   req_q;

  // Per-button debounce FSM and saturating counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < N_B; b++) begin
        state_q[b] <= ST_LOW;
        cnt_q[b]   <= '0;
      end
      req_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  // Next state. A press request is raised only on the WAIT_HIGH -> HIGH step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = '0;
    for (int b = 0; b < N_B; b++) begin
      case (state_q[b])
        ST_LOW: begin
          if (btn_sync[b]) begin
            state_d[b] = ST_WAIT_HIGH;
            cnt_d[b]   = CNT_ONE;
          end
        end
        ST_WAIT_HIGH: begin
          if (btn_sync[b]) begin
            if (cnt_q[b] >= CNT_LAST) begin
              state_d[b] = ST_HIGH;
              cnt_d[b]   = CNT_MAX;
              req_d[b]   = 1'b1;
            end else begin
              cnt_d[b] = cnt_q[b] + CNT_ONE;
            end
          end else begin
            state_d[b] = ST_LOW;
            cnt_d[b]   = '0;
          end
        end
        ST_HIGH: begin
          if (!btn_sync[b]) begin
            state_d[b] = ST_WAIT_LOW;
            cnt_d[b]   = CNT_ONE;
          end
        end
        ST_WAIT_LOW: begin
          if (!btn_sync[b]) begin
            if (cnt_q[b] >= CNT_LAST) begin
              state_d[b] = ST_LOW;
              cnt_d[b]   = CNT_MAX;
            end else begin
              cnt_d[b] = cnt_q[b] + CNT_ONE;
            end
          end else begin
            state_d[b] = ST_HIGH;
            cnt_d[b]   = '0;
          end
        end
        default: begin
          state_d[b] = ST_LOW;
          cnt_d[b]   = '0;
        end
      endcase
    end
  end

  // The registered request adds the stage that places the pulse at DB_CYCLES+3.
  assign press_req = req_q;

`else

  logic [N_B-1:0] btn_sync_d;

  // Previous synchronized level for rising-edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_sync_d <= '0;
    end else begin
      btn_sync_d <= btn_sync;
    end
  end

  assign press_req = btn_sync & ~btn_sync_d;

`endif

  // Highest-index request wins. Losers are dropped, never queued.
  always_comb begin
    grant_c = '0;
    for (int b = 0; b < N_B; b++) begin
      if (press_req[b]) begin
        grant_c = N_B'(1) << b;
      end
    end
  end

  // Registered pulse output. Switches are captured on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      o_buttons <= '0;
      o_SWs     <= '0;
    end else begin
      o_buttons <= grant_c;
      if (|press_req) begin
        o_SWs <= sw_sync;
      end
    end
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The block SHALL have parameter N_SW, default 6, meaning switch bus width.
REQ-002 The block SHALL have parameter N_B, default 3, meaning button count (bit 2 = load A, bit 1 = load B, bit 0 = load OP).
REQ-003 The block SHALL have parameter DB_CYCLES, default 16, meaning the number of consecutive equal samples that qualify a level change (minimum 2).
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port i_SWs, input, N_SW bits: raw, asynchronous switch levels.
REQ-007 The block SHALL have port i_buttons, input, N_B bits: raw, asynchronous, bouncing push-buttons, active-high.
REQ-008 The block SHALL have port o_SWs, output, N_SW bits: switch value captured with the last press pulse; it feeds the ALU top i_SWs.
REQ-009 The block SHALL have port o_buttons, output, N_B bits: one-cycle, at-most-one-hot press pulses; they feed the ALU top i_buttons.

Function
REQ-010 Every i_buttons bit and every i_SWs bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Each button SHALL have an independent FSM with states LOW, WAIT_HIGH, HIGH and WAIT_LOW, plus a counter of width clog2(DB_CYCLES+1).
- LOW: synced=1 -> WAIT_HIGH, count=1.
- WAIT_HIGH: synced=1 -> count+1; on reaching DB_CYCLES -> HIGH. synced=0 -> LOW, count=0.
- HIGH: synced=0 -> WAIT_LOW, count=1.
- WAIT_LOW: synced=0 -> count+1; on reaching DB_CYCLES -> LOW. synced=1 -> HIGH, count=0.
REQ-012 On every transition WAIT_HIGH->HIGH, the block SHALL raise a press request; no other transition raises one.
REQ-013 o_buttons SHALL be registered, and a press request SHALL appear as exactly one clock cycle of o_buttons.
REQ-014 When a raw button goes high cleanly and stays high, its pulse SHALL assert exactly DB_CYCLES+3 rising edges after the first edge that samples it high.
REQ-015 A high level lasting fewer than DB_CYCLES synchronized samples SHALL produce no pulse.
REQ-016 Bounce on release SHALL produce no pulse.
REQ-017 A button held indefinitely SHALL produce exactly one pulse.
REQ-018 If more than one press request occurs on the same edge, only the highest-index bit SHALL be asserted; the others SHALL be dropped and SHALL NOT be re-issued.
REQ-019 o_SWs SHALL load the synchronized switch value on the same edge that asserts any o_buttons bit; it SHALL hold its value otherwise.
REQ-020 Counters SHALL saturate at DB_CYCLES and SHALL never wrap.

Reset
REQ-021 reset=0 SHALL asynchronously clear all synchronizer flops, counters, o_SWs and o_buttons to 0, and SHALL force every FSM to LOW.
REQ-022 Deasserting reset SHALL take effect at the next clock edge.
REQ-023 A button held through reset deassertion SHALL yield one pulse DB_CYCLES+3 edges later.
REQ-024 Reset asserted mid-debounce SHALL abort the debounce with no pulse.
REQ-025 Reset asserted in the same cycle as a pulse SHALL force that pulse low immediately.

Configuration
REQ-026 With macro INPUT_CONDITIONER_DEBOUNCE_EN defined, the FSM and counter logic of REQ-011 to REQ-020 SHALL be built.
REQ-027 Without INPUT_CONDITIONER_DEBOUNCE_EN, FSMs and counters SHALL be omitted, and each pulse SHALL be a rising-edge detect of the synchronized level, asserting 3 edges after the first high sample.
REQ-028 Without INPUT_CONDITIONER_DEBOUNCE_EN, REQ-018, REQ-019 and the Reset requirements SHALL still apply.

Verification
REQ-029 Clean press: DB_CYCLES=16, i_SWs=6'b101010, i_buttons=3'b100 held 40 cycles -> o_buttons=3'b100 for 1 cycle at edge 19, and o_SWs=6'b101010 from the same edge.
REQ-030 Glitch: i_buttons[1] high 10 cycles, then 0 -> o_buttons stays 0; o_SWs unchanged.
REQ-031 Bounce: i_buttons[0] toggling every 3 cycles for 30 cycles, then stable high -> exactly one pulse, 19 edges after the stable start; release bounce -> no pulse.
REQ-032 Simultaneous: i_buttons=3'b111 stable from the same edge -> exactly one pulse, o_buttons=3'b100; no later pulse for bits 1 or 0.
REQ-033 Reset mid-debounce: press bit 2 and drive reset=0 at count 8 for 2 cycles while the button stays held -> all outputs 0 during reset, then one pulse 19 edges after reset release.
REQ-034 Macro off: i_buttons=3'b001 rising -> o_buttons=3'b001 for 1 cycle, 3 edges later.
